// File: rtl/key_click_decoder.sv
// Groups debounced press pulses into 1/2/3-click events and steps a display mode index:
// forward on single, backward on double, home on triple.
module key_click_decoder #(
    parameter int GAP_CYCLES = 22_275_000,
    parameter int CNT_W      = 25,
    parameter int NUM_MODES  = 8,
    parameter int MODE_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_fall,
    output logic              click_valid,
    output logic [1:0]        click_count,
    output logic [MODE_W-1:0] mode_idx,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    state_t           state;
    logic [1:0]       clicks;
    logic [CNT_W-1:0] gap_cnt;

    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                    input logic [1:0]        n);
        case (n)
            2'd1:    next_mode = (cur == MODE_LAST) ? '0 : cur + MODE_W'(1);
            2'd2:    next_mode = (cur == '0) ? MODE_LAST : cur - MODE_W'(1);
            default: next_mode = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            clicks      <= 2'd0;
            gap_cnt     <= '0;
            click_valid <= 1'b0;
            click_count <= 2'd0;
            mode_idx    <= '0;
            busy        <= 1'b0;
        end else begin
            click_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (key_fall) begin
                        clicks  <= 2'd1;
                        gap_cnt <= '0;
                        state   <= S_WAIT;
                        busy    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    // A press beats a coinciding timeout: it is counted and the window restarts.
                    if (key_fall) begin
                        gap_cnt <= '0;
                        if (clicks == 2'd2) begin
                            clicks      <= 2'd3;
                            state       <= S_EMIT;
                            click_valid <= 1'b1;
                            click_count <= 2'd3;
                            mode_idx    <= next_mode(mode_idx, 2'd3);
                        end else begin
                            clicks <= clicks + 2'd1;
                        end
                    end else if (gap_cnt == GAP_LAST) begin
                        state       <= S_EMIT;
                        click_valid <= 1'b1;
                        click_count <= clicks;
                        mode_idx    <= next_mode(mode_idx, clicks);
                    end else begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    // A press landing on the emit cycle opens the next group.
                    if (key_fall) begin
                        clicks  <= 2'd1;
                        gap_cnt <= '0;
                        state   <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with GAP_CYCLES=8, NUM_MODES=8.
module tb_key_click_decoder;

    logic       clk;
    logic       rst_n;
    logic       key_fall;
    logic       click_valid;
    logic [1:0] click_count;
    logic [2:0] mode_idx;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    key_click_decoder #(
        .GAP_CYCLES(8),
        .CNT_W     (4),
        .NUM_MODES (8),
        .MODE_W    (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_fall   (key_fall),
        .click_valid(click_valid),
        .click_count(click_count),
        .mode_idx   (mode_idx),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pulses;   // bit e set: key_fall sampled at edge e
        int          ev0;
        int          cnt0;
        int          mode0;
        int          ev1;      // -1 when only one event is expected
        int          cnt1;
        int          mode1;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive key_fall for the coming edge; return 1 time unit after that edge.
    task automatic step(input logic kf);
        key_fall = kf;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   nev;
        int   ev_c[2];
        int   ev_n[2];
        int   ev_m[2];
        int   last_ev;
        int   exp_nev;
        logic pv;
        nev     = 0;
        pv      = 1'b0;
        ev_c    = '{-1, -1};
        ev_n    = '{0, 0};
        ev_m    = '{0, 0};
        last_ev = (v.ev1 >= 0) ? v.ev1 : v.ev0;
        exp_nev = (v.ev1 >= 0) ? 2 : 1;
        for (int e = 0; e < 32; e++) begin
            step(v.pulses[e]);
            if (e == 1) chk({tag, "_busy_open"}, 32'(busy), 32'd1);
            if (click_valid) begin
                chk({tag, "_valid_gap"}, 32'(pv), 32'd0);
                if (nev < 2) begin
                    ev_c[nev] = e;
                    ev_n[nev] = int'(click_count);
                    ev_m[nev] = int'(mode_idx);
                end
                nev++;
            end
            if (e == last_ev + 1) chk({tag, "_busy_closed"}, 32'(busy), 32'd0);
            pv = click_valid;
        end
        key_fall = 1'b0;
        chk({tag, "_events"}, 32'(nev), 32'(exp_nev));
        chk({tag, "_ev0_cycle"}, 32'(ev_c[0]), 32'(v.ev0));
        chk({tag, "_ev0_count"}, 32'(ev_n[0]), 32'(v.cnt0));
        chk({tag, "_ev0_mode"},  32'(ev_m[0]), 32'(v.mode0));
        if (v.ev1 >= 0) begin
            chk({tag, "_ev1_cycle"}, 32'(ev_c[1]), 32'(v.ev1));
            chk({tag, "_ev1_count"}, 32'(ev_n[1]), 32'(v.cnt1));
            chk({tag, "_ev1_mode"},  32'(ev_m[1]), 32'(v.mode1));
        end
        chk({tag, "_count_hold"}, 32'(click_count), 32'((v.ev1 >= 0) ? v.cnt1 : v.cnt0));
    endtask

    vec_t vecs[7];
    vec_t single;

    initial begin
        int rose;
        int busy_seen;

        vecs[0] = '{32'h0000_0001,  8, 1, 1, -1, 0, 0};  // single: 0 -> 1
        vecs[1] = '{32'h0000_0021, 13, 2, 0, -1, 0, 0};  // double: 1 -> 0
        vecs[2] = '{32'h0000_0021, 13, 2, 7, -1, 0, 0};  // double: 0 -> 7 wrap
        vecs[3] = '{32'h0000_00C9,  6, 3, 0, 15, 1, 1};  // triple, then press in EMIT
        vecs[4] = '{32'h0000_0101, 16, 2, 0, -1, 0, 0};  // press on last gap cycle still counts
        vecs[5] = '{32'h0000_0201,  8, 1, 1, 17, 1, 2};  // press one cycle late: two singles
        vecs[6] = '{32'h0000_0007,  2, 3, 0, -1, 0, 0};  // back-to-back triple

        rst_n    = 1'b0;
        key_fall = 1'b0;

        // Reset held with random presses
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)));
            chk($sformatf("reset_outputs_%0d", i),
                32'({click_valid, click_count, mode_idx, busy}), 32'd0);
        end
        key_fall = 1'b0;
        rst_n    = 1'b1;
        rose      = 0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (click_valid) rose++;
            if (busy) busy_seen++;
        end
        chk("idle_no_valid", 32'(rose), 32'd0);
        chk("idle_no_busy", 32'(busy_seen), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Eight spaced singles from mode 0 come back to 0
        for (int i = 1; i <= 8; i++) begin
            single = '{32'h0000_0001, 8, 1, i % 8, -1, 0, 0};
            run_vec(single, $sformatf("wrap%0d", i));
        end

        // Reset in the middle of an open group discards it
        single = '{32'h0000_0001, 8, 1, 1, -1, 0, 0};
        run_vec(single, "pre_abort");
        step(1'b1);
        for (int e = 1; e < 4; e++) step(1'b0);
        chk("abort_busy_before", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({click_valid, click_count, mode_idx, busy}), 32'd0);
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        rose  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (click_valid) rose++;
        end
        chk("abort_no_valid", 32'(rose), 32'd0);
        chk("abort_mode", 32'(mode_idx), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
